// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   An op issued with Start in IDLE has its result computed immediately into a
//   staging register; the unit then holds Busy for the op's latency and
//   commits the staged result to HI/LO on the cycle Busy falls.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (aborts an in-flight op)
//   Start  issue MDOp this cycle (ignored while Busy)
//   MDOp   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MADDU,8 MSUB,9 MSUBU
//   SrcA   operand A / dividend / MTHI-MTLO source
//   SrcB   operand B / divisor
//   Busy   operation in flight
//   HI/LO  architectural result registers
// Configuration macro: MDU_MADD_EN enables ops 6..9 (accumulate); otherwise
//   those encodings are no-ops.
module mult_div_unit #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [3:0]       MDOp,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             Busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned DW      = 2 * WIDTH;
   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic [DW-1:0]      r_stage;
   logic               r_stage_wr;

   logic               w_accept, w_commit, w_mthi, w_mtlo;
   logic               w_op_long, w_op_mult_class;
   logic [DW-1:0]      w_res;
   logic               w_res_wr;

   // Products: extend to 2*WIDTH first so a truncated unsigned multiply
   // yields the correctly wrapped signed or unsigned product.
   logic [DW-1:0]      w_a_sx, w_b_sx, w_a_zx, w_b_zx, w_prod_s, w_prod_u;
   assign w_a_sx   = {{WIDTH{SrcA[WIDTH-1]}}, SrcA};
   assign w_b_sx   = {{WIDTH{SrcB[WIDTH-1]}}, SrcB};
   assign w_a_zx   = {{WIDTH{1'b0}}, SrcA};
   assign w_b_zx   = {{WIDTH{1'b0}}, SrcB};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = w_a_zx * w_b_zx;

   // Division: a divisor of 1 replaces zero (result discarded) and the
   // MIN/-1 overflow case (MIN/1 gives exactly LO=MIN, HI=0).
   logic               w_b_zero, w_div_ovf;
   logic signed [WIDTH-1:0] w_sa, w_sb_div, w_quo_s, w_rem_s;
   logic [WIDTH-1:0]   w_ub_div, w_quo_u, w_rem_u;
   assign w_b_zero  = (SrcB == '0);
   assign w_div_ovf = (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
   assign w_sa      = $signed(SrcA);
   assign w_sb_div  = (w_b_zero || w_div_ovf) ? $signed(WIDTH'(1)) : $signed(SrcB);
   assign w_ub_div  = w_b_zero ? WIDTH'(1) : SrcB;
   assign w_quo_s   = w_sa / w_sb_div;
   assign w_rem_s   = w_sa % w_sb_div;
   assign w_quo_u   = SrcA / w_ub_div;
   assign w_rem_u   = SrcA % w_ub_div;

`ifdef MDU_MADD_EN
   logic [DW-1:0]      w_acc;
   assign w_acc = {r_hi, r_lo};
`endif

   // Op decode and staged result selection.
   always_comb begin
      w_op_long       = 1'b0;
      w_op_mult_class = 1'b0;
      w_res           = '0;
      w_res_wr        = 1'b1;
      case (MDOp)
         4'd0: begin w_op_long = 1'b1; w_op_mult_class = 1'b1; w_res = w_prod_s; end
         4'd1: begin w_op_long = 1'b1; w_op_mult_class = 1'b1; w_res = w_prod_u; end
         4'd2: begin
            w_op_long = 1'b1;
            w_res     = {w_rem_s, w_quo_s};
            w_res_wr  = !w_b_zero;
         end
         4'd3: begin
            w_op_long = 1'b1;
            w_res     = {w_rem_u, w_quo_u};
            w_res_wr  = !w_b_zero;
         end
`ifdef MDU_MADD_EN
         4'd6: begin w_op_long = 1'b1; w_op_mult_class = 1'b1; w_res = w_acc + w_prod_s; end
         4'd7: begin w_op_long = 1'b1; w_op_mult_class = 1'b1; w_res = w_acc + w_prod_u; end
         4'd8: begin w_op_long = 1'b1; w_op_mult_class = 1'b1; w_res = w_acc - w_prod_s; end
         4'd9: begin w_op_long = 1'b1; w_op_mult_class = 1'b1; w_res = w_acc - w_prod_u; end
`endif
         default: ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // FSM next-state and control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      w_mthi      = 1'b0;
      w_mtlo      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               if (w_op_long) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_RUN;
                  w_cnt_nxt   = w_op_mult_class ? CNT_W'(MULT_CYCLES - 1)
                                                : CNT_W'(DIV_CYCLES - 1);
               end else if (MDOp == 4'd4) begin
                  w_mthi = 1'b1;
               end else if (MDOp == 4'd5) begin
                  w_mtlo = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (r_cnt == '0) begin
               w_commit    = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Staging and HI/LO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi       <= '0;
         r_lo       <= '0;
         r_stage    <= '0;
         r_stage_wr <= 1'b0;
      end else begin
         if (w_accept) begin
            r_stage    <= w_res;
            r_stage_wr <= w_res_wr;
         end
         if (w_commit && r_stage_wr) begin
            {r_hi, r_lo} <= r_stage;
         end else if (w_mthi) begin
            r_hi <= SrcA;
         end else if (w_mtlo) begin
            r_lo <= SrcA;
         end
      end
   end

   assign Busy = (r_state == S_RUN);
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [3:0]  MDOp;
   logic [31:0] SrcA, SrcB;
   logic        Busy;
   logic [31:0] HI, LO;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
      .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_op(input string name, input logic [31:0] hi,
                            input logic [31:0] lo, input int cyc);
      exp_t e;
      e.name = name; e.hi = hi; e.lo = lo; e.cyc = cyc;
      sb.push_back(e);
   endtask

   // Called at a negedge; Start is sampled on the following posedge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
      @(negedge clk);
      Start = 1'b0; MDOp = 4'd15; SrcA = '0; SrcB = '0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (Busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (Busy) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: Busy still 1 after %0d cycles, required 0", name, n);
      end
      @(negedge clk);
   endtask

   // Monitor: on each falling Busy, pop an expectation and compare.
   initial begin
      int   busy_cnt = 0;
      logic prev_busy = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (Busy) begin
            busy_cnt++;
         end else if (prev_busy) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_op: Busy fell after %0d cycles, none required", busy_cnt);
            end else begin
               e = sb.pop_front();
               check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cyc));
               check({e.name, "_HI"}, HI, e.hi);
               check({e.name, "_LO"}, LO, e.lo);
            end
            busy_cnt = 0;
         end
         prev_busy = Busy;
      end
   end

   initial begin
      reset = 1'b1; Start = 1'b0; MDOp = 4'd15; SrcA = '0; SrcB = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", 32'(Busy), 32'd0);
      check("reset_HI", HI, 32'h0);
      check("reset_LO", LO, 32'h0);

      // 1: MULT / MULTU
      expect_op("mult", 32'hFFFFFFFF, 32'h0C68F758, 5);
      issue(4'd0, 32'h86347BAC, 32'h2);
      wait_idle("mult");
      expect_op("multu", 32'h00000001, 32'h0C68F758, 5);
      issue(4'd1, 32'h86347BAC, 32'h2);
      wait_idle("multu");

      // 2: DIV / DIVU / overflow
      expect_op("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(4'd2, 32'hFFFFFFF9, 32'h2);
      wait_idle("div");
      expect_op("divu", 32'h00000001, 32'h7FFFFFFC, 10);
      issue(4'd3, 32'hFFFFFFF9, 32'h2);
      wait_idle("divu");
      expect_op("div_ovf", 32'h0, 32'h80000000, 10);
      issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_idle("div_ovf");

      // 3: MTHI / MTLO, then divide by zero preserves them
      issue(4'd4, 32'h1234, 32'h0);
      check("mthi_busy", 32'(Busy), 32'd0);
      check("mthi_HI", HI, 32'h1234);
      check("mthi_LO", LO, 32'h80000000);
      issue(4'd5, 32'h5678, 32'h0);
      check("mtlo_busy", 32'(Busy), 32'd0);
      check("mtlo_LO", LO, 32'h5678);
      expect_op("div0", 32'h1234, 32'h5678, 10);
      issue(4'd2, 32'h77, 32'h0);
      wait_idle("div0");

      // Undefined op: no effect
      issue(4'd12, 32'hDEAD, 32'hBEEF);
      check("undef_busy", 32'(Busy), 32'd0);
      check("undef_HI", HI, 32'h1234);
      check("undef_LO", LO, 32'h5678);

      // 4: Start while Busy is ignored
      expect_op("mult_busy_start", 32'h0, 32'h0000000C, 5);
      issue(4'd0, 32'd3, 32'd4);
      issue(4'd3, 32'd9, 32'd2);
      wait_idle("mult_busy_start");
      repeat (12) @(negedge clk);
      check("ignored_busy", 32'(Busy), 32'd0);
      check("ignored_LO", LO, 32'h0000000C);

      // 5: reset mid-DIV aborts without commit
      issue(4'd2, 32'd100, 32'd7);
      @(negedge clk);
      expect_op("reset_abort", 32'h0, 32'h0, 2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_HI", HI, 32'h0);
      check("abort_LO", LO, 32'h0);
      expect_op("mult_after_reset", 32'hFFFFFFFF, 32'hFFFFFFF9, 5);
      issue(4'd0, 32'd7, 32'hFFFFFFFF);
      wait_idle("mult_after_reset");

      // 6: accumulate ops
      issue(4'd5, 32'd5, 32'd0);
      issue(4'd4, 32'd0, 32'd0);
`ifdef MDU_MADD_EN
      expect_op("madd", 32'h0, 32'h00000011, 5);
      issue(4'd6, 32'd3, 32'd4);
      wait_idle("madd");
      expect_op("msubu", 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
      issue(4'd9, 32'h2, 32'h10);
      wait_idle("msubu");
`else
      issue(4'd6, 32'd3, 32'd4);
      check("madd_off_busy", 32'(Busy), 32'd0);
      repeat (6) @(negedge clk);
      check("madd_off_HI", HI, 32'h0);
      check("madd_off_LO", LO, 32'h5);
`endif

      begin
         int n = 0;
         while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
         end
      end
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
